// File: rtl/memory_access_controller_if.sv
// Client handshake and Memory_unit pin bundle for memory_access_controller.
// slave = controller side, master = client plus memory side.
interface memory_access_controller_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_busy;
  logic                  mem_op;
  logic                  mem_select;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_in_bus;
  logic [DATA_WIDTH-1:0] mem_out_bus;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_out_bus,
    output req_ready, rsp_valid, rsp_rdata, init_busy,
           mem_op, mem_select, mem_address, mem_in_bus
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_out_bus,
    input  req_ready, rsp_valid, rsp_rdata, init_busy,
           mem_op, mem_select, mem_address, mem_in_bus
  );
endinterface

// File: rtl/memory_access_controller.sv
// Sequences single-beat client requests into SETUP/ACCESS/HOLD pulses for the
// latch-based Memory_unit and zero-fills every word after reset.
//
// state       | meaning
// INIT_SETUP  | zero-fill: address/op/data driven, select low
// INIT_ACCESS | zero-fill: select high
// INIT_HOLD   | zero-fill: select low, advance or finish
// IDLE        | ready for a client request
// SETUP       | client access: address/op/data driven, select low
// ACCESS      | client access: select high, read data sampled at exit
// HOLD        | client access: select low, rsp_valid high
module memory_access_controller #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic                       clk,
  input logic                       rst_n,
  memory_access_controller_if.slave bus
);

  localparam logic [2:0] ST_INIT_SETUP  = 3'd0;
  localparam logic [2:0] ST_INIT_ACCESS = 3'd1;
  localparam logic [2:0] ST_INIT_HOLD   = 3'd2;
  localparam logic [2:0] ST_IDLE        = 3'd3;
  localparam logic [2:0] ST_SETUP       = 3'd4;
  localparam logic [2:0] ST_ACCESS      = 3'd5;
  localparam logic [2:0] ST_HOLD        = 3'd6;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  mem_select_q, mem_select_d;
  logic                  mem_op_q, mem_op_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_in_bus_q, mem_in_bus_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  init_busy_q, init_busy_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_select_d  = 1'b0;
    mem_op_d      = mem_op_q;
    mem_address_d = mem_address_q;
    mem_in_bus_d  = mem_in_bus_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    init_busy_d   = init_busy_q;

    case (state_q)
      ST_INIT_SETUP: begin
        // op is forced here too because reset leaves it low during the first setup
        state_d       = ST_INIT_ACCESS;
        mem_select_d  = 1'b1;
        mem_op_d      = 1'b1;
        mem_address_d = cnt_q;
        mem_in_bus_d  = '0;
      end
      ST_INIT_ACCESS: begin
        state_d = ST_INIT_HOLD;
      end
      ST_INIT_HOLD: begin
        if (cnt_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          init_busy_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d       = ST_INIT_SETUP;
          cnt_d         = cnt_q + ADDR_WIDTH'(1);
          mem_op_d      = 1'b1;
          mem_address_d = cnt_q + ADDR_WIDTH'(1);
          mem_in_bus_d  = '0;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d       = ST_SETUP;
          mem_op_d      = bus.req_op;
          mem_address_d = bus.req_addr;
          mem_in_bus_d  = bus.req_wdata;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d      = ST_ACCESS;
        mem_select_d = 1'b1;
      end
      ST_ACCESS: begin
        state_d     = ST_HOLD;
        rsp_valid_d = 1'b1;
        if (!mem_op_q) begin
          rsp_rdata_d = bus.mem_out_bus;
        end
      end
      ST_HOLD: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        init_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT_ON_RESET ? ST_INIT_SETUP : ST_IDLE;
      cnt_q         <= '0;
      mem_select_q  <= 1'b0;
      mem_op_q      <= 1'b0;
      mem_address_q <= '0;
      mem_in_bus_q  <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      init_busy_q   <= INIT_ON_RESET;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_select_q  <= mem_select_d;
      mem_op_q      <= mem_op_d;
      mem_address_q <= mem_address_d;
      mem_in_bus_q  <= mem_in_bus_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      init_busy_q   <= init_busy_d;
    end
  end

  assign bus.mem_select  = mem_select_q;
  assign bus.mem_op      = mem_op_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_in_bus  = mem_in_bus_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.init_busy   = init_busy_q;

  // Handshake sanity: a response cycle is never also an accept cycle.
  a_no_rsp_ready_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_valid_q && req_ready_q));
  a_select_only_in_access: assert property (@(posedge clk) disable iff (!rst_n)
    mem_select_q |-> (state_q == ST_ACCESS || state_q == ST_INIT_ACCESS));

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: behavioural Memory_unit, vector table,
// response scoreboard and select-pulse monitor.
module tb_memory_access_controller;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_access_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memory_access_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model starts with non-zero garbage so the zero-fill is observable.
  logic [DW-1:0] mem_arr [2**AW];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 2**AW; i++) mem_arr[i] <= 8'(i + 161);
      seeded <= 1'b1;
    end else if (bus.mem_select && bus.mem_op) begin
      mem_arr[bus.mem_address] <= bus.mem_in_bus;
    end
  end
  assign bus.mem_out_bus = (bus.mem_select && !bus.mem_op) ? mem_arr[bus.mem_address] : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_rd;
    logic [7:0]  data;
    int          acc;
  } sb_t;
  sb_t sb[$];

  int         init_pulses = 0;
  int         next_init_addr = 0;
  logic [7:0] last_rd = '0;
  bit         prev_sel = 1'b0;
  logic [2:0] prev_addr = '0;

  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      init_pulses    = 0;
      next_init_addr = 0;
      last_rd        = '0;
      prev_sel       = 1'b0;
    end else begin
      if (bus.mem_select) begin
        chk("sel_one_cycle", int'(prev_sel), 0);
        chk("addr_before_sel", int'(bus.mem_address), int'(prev_addr));
        if (bus.init_busy) begin
          chk("init_addr", int'(bus.mem_address), next_init_addr);
          chk("init_op", int'(bus.mem_op), 1);
          chk("init_data", int'(bus.mem_in_bus), 0);
          init_pulses++;
          next_init_addr++;
        end
      end else if (prev_sel) begin
        chk("addr_after_sel", int'(bus.mem_address), int'(prev_addr));
      end
      if (bus.init_busy) chk("ready_during_init", int'(bus.req_ready), 0);
      if (bus.rsp_valid) begin
        chk("rsp_ready_overlap", int'(bus.req_ready), 0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", int'(bus.rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_latency", cyc - e.acc, 3);
          if (e.is_rd) begin
            chk("rsp_rdata", int'(bus.rsp_rdata), int'(e.data));
            last_rd = e.data;
          end else begin
            chk("wr_keeps_rdata", int'(bus.rsp_rdata), int'(last_rd));
          end
        end
      end
    end
    prev_sel  = bus.mem_select;
    prev_addr = bus.mem_address;
  end

  task automatic wait_accept(output int c, output bit ok);
    int n = 0;
    ok = 1'b0;
    c  = 0;
    while (n < 100) begin
      if (bus.req_ready && bus.req_valid) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) chk("accept_timeout", int'(ok), 1);
  endtask

  task automatic push_exp(input bit op, input int exp_rd, input int c);
    sb_t e;
    e.is_rd = !op;
    e.data  = exp_rd[7:0];
    e.acc   = c;
    sb.push_back(e);
  endtask

  task automatic issue(input bit op, input int addr, input int wdata, input int exp_rd);
    int c;
    bit ok;
    bus.req_op    = op;
    bus.req_addr  = addr[AW-1:0];
    bus.req_wdata = wdata[DW-1:0];
    bus.req_valid = 1'b1;
    wait_accept(c, ok);
    if (ok) push_exp(op, exp_rd, c);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Called one step after the last reset edge, i.e. in cycle 1 of the fill.
  task automatic check_init();
    int n = 0;
    chk("init_busy_start", int'(bus.init_busy), 1);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_rise_cycle", n + 1, 25);
    chk("init_pulses", init_pulses, 8);
    chk("init_busy_end", int'(bus.init_busy), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  typedef struct {
    bit op;
    int addr;
    int wdata;
    int exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    int c1, c2, r;
    bit ok1, ok2;

    vecs[0] = '{1'b1, 0, 'h55, 0};
    vecs[1] = '{1'b0, 0, 0, 'h55};
    vecs[2] = '{1'b0, 4, 0, 'h00};
    vecs[3] = '{1'b1, 4, 'hF0, 0};
    vecs[4] = '{1'b0, 4, 0, 'hF0};
    vecs[5] = '{1'b0, 3, 0, 'h00};
    vecs[6] = '{1'b1, 7, 'hAA, 0};
    vecs[7] = '{1'b0, 7, 0, 'hAA};
    vecs[8] = '{1'b0, 0, 0, 'h55};

    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_select", int'(bus.mem_select), 0);
    chk("rst_op", int'(bus.mem_op), 0);
    chk("rst_address", int'(bus.mem_address), 0);
    chk("rst_in_bus", int'(bus.mem_in_bus), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rdata", int'(bus.rsp_rdata), 0);
    chk("rst_init_busy", int'(bus.init_busy), 1);

    #1 rst_n = 1'b1;
    check_init();

    for (int a = 0; a < 8; a++) issue(1'b0, a, 0, 0);

    for (int i = 0; i < 9; i++) issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Backpressure: valid held high across two distinct requests.
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd5;
    bus.req_wdata = 8'h11;
    bus.req_valid = 1'b1;
    wait_accept(c1, ok1);
    if (ok1) push_exp(1'b1, 0, c1);
    @(posedge clk);
    #1 bus.req_op = 1'b0;
    wait_accept(c2, ok2);
    if (ok2) push_exp(1'b0, 'h11, c2);
    chk("bp_spacing", c2 - c1, 4);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    drain();

    // Reset in the ACCESS phase of a write of 0x3C to addr 2.
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd2;
    bus.req_wdata = 8'h3C;
    bus.req_valid = 1'b1;
    wait_accept(c1, ok1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_sel_high", int'(bus.mem_select), 1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_select", int'(bus.mem_select), 0);
    chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("mid_rst_init_busy", int'(bus.init_busy), 1);
    chk("mid_rst_rdata", int'(bus.rsp_rdata), 0);
    chk("mid_rst_ready", int'(bus.req_ready), 0);

    // A request held through the whole refill is taken only once it ends.
    bus.req_op    = 1'b1;
    bus.req_addr  = 3'd6;
    bus.req_wdata = 8'h77;
    bus.req_valid = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    r = cyc;
    check_init();
    wait_accept(c1, ok1);
    if (ok1) push_exp(1'b1, 0, c1);
    chk("held_accept_cycle", c1 - r, 24);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    issue(1'b0, 2, 0, 'h00);
    issue(1'b0, 6, 0, 'h77);
    issue(1'b0, 7, 0, 'h00);
    drain();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end
endmodule
